// File: rtl/eeg_wram_rdgen_if.sv
// Channel bundle for eeg_wram_rdgen: job config, WRAM address/data and packed-output handshakes.
// master = the read generator, slave = the surrounding WRAM/engine environment.
interface eeg_wram_rdgen_if #(
  parameter int unsigned ADD_AW   = 13,
  parameter int unsigned DAT_DW   = 8,
  parameter int unsigned PACK_NUM = 4
);
  logic                       CFG_VLD;
  logic                       CFG_RDY;
  logic [ADD_AW-1:0]          CFG_BASE;
  logic [ADD_AW-1:0]          CFG_STRD;
  logic [ADD_AW-1:0]          CFG_LEN;

  logic                       ADD_VLD;
  logic                       ADD_LST;
  logic                       ADD_RDY;
  logic [ADD_AW-1:0]          ADD_ADD;

  logic                       DAT_VLD;
  logic                       DAT_LST;
  logic                       DAT_RDY;
  logic [DAT_DW-1:0]          DAT_DAT;

  logic                       OUT_VLD;
  logic                       OUT_LST;
  logic                       OUT_RDY;
  logic [PACK_NUM*DAT_DW-1:0] OUT_DAT;

  modport master (
    input  CFG_VLD, CFG_BASE, CFG_STRD, CFG_LEN,
    output CFG_RDY,
    output ADD_VLD, ADD_LST, ADD_ADD,
    input  ADD_RDY,
    input  DAT_VLD, DAT_LST, DAT_DAT,
    output DAT_RDY,
    output OUT_VLD, OUT_LST, OUT_DAT,
    input  OUT_RDY
  );

  modport slave (
    output CFG_VLD, CFG_BASE, CFG_STRD, CFG_LEN,
    input  CFG_RDY,
    input  ADD_VLD, ADD_LST, ADD_ADD,
    output ADD_RDY,
    output DAT_VLD, DAT_LST, DAT_DAT,
    input  DAT_RDY,
    input  OUT_VLD, OUT_LST, OUT_DAT,
    output OUT_RDY
  );
endinterface

// File: rtl/eeg_wram_rdgen.sv
// Strided WRAM read generator: credit-limited address issue, return FIFO, LSB-first word packer.
// Define EEG_RDGEN_ERRCHK_EN to enable the sticky DAT_LST position check on ERR.
module eeg_wram_rdgen #(
  parameter int unsigned ADD_AW   = 13,
  parameter int unsigned DAT_DW   = 8,
  parameter int unsigned PACK_NUM = 4,
  parameter int unsigned CRD_NUM  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   IS_IDLE,
  output logic                   DONE,
  output logic                   ERR,
  eeg_wram_rdgen_if.master       bus
);

  localparam int unsigned CW = $clog2(CRD_NUM + 1);
  localparam int unsigned PW = (CRD_NUM > 1) ? $clog2(CRD_NUM) : 1;
  localparam int unsigned SW = $clog2(PACK_NUM);
  localparam logic [CW-1:0] CRD_MAX   = CW'(CRD_NUM);
  localparam logic [PW-1:0] PTR_LAST  = PW'(CRD_NUM - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(PACK_NUM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_nxt;

  logic [ADD_AW-1:0]          len_q, strd_q, addr_q, iss_cnt, pop_cnt;
  logic [CW-1:0]              outst_cnt, fifo_cnt;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [DAT_DW-1:0]          fifo_mem [CRD_NUM];
  logic [SW-1:0]              slot;
  logic [PACK_NUM*DAT_DW-1:0] pk_dat, pk_nxt, out_dat;
  logic                       out_vld, out_lst, done_zl;
  logic                       cfg_hs, add_vld, add_lst, add_hs, out_hs;
  logic                       push, pop, pk_full, pk_last;

  always_comb begin
    cfg_hs  = bus.CFG_VLD && (state == IDLE);
    add_lst = (iss_cnt == len_q - 1'b1);
    // outst_cnt covers both in-flight reads and FIFO occupancy
    add_vld = (state == ISSUE) && (outst_cnt != CRD_MAX);
    add_hs  = add_vld && bus.ADD_RDY;
    out_hs  = out_vld && bus.OUT_RDY;
    push    = bus.DAT_VLD && (state != IDLE);
    pop     = (fifo_cnt != '0) && (!out_vld || bus.OUT_RDY);
    pk_last = (pop_cnt == len_q - 1'b1);
    pk_full = (slot == SLOT_LAST);
    pk_nxt  = pk_dat;
    pk_nxt[slot*DAT_DW +: DAT_DW] = fifo_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    IS_IDLE     = (state == IDLE);
    bus.CFG_RDY = (state == IDLE);
    bus.ADD_VLD = add_vld;
    bus.ADD_LST = add_vld && add_lst;
    bus.ADD_ADD = addr_q;
    bus.DAT_RDY = 1'b1;
    bus.OUT_VLD = out_vld;
    bus.OUT_LST = out_lst;
    bus.OUT_DAT = out_dat;
    DONE        = done_zl || (out_hs && out_lst);
    case (state)
      IDLE:    if (cfg_hs && (bus.CFG_LEN != '0)) state_nxt = ISSUE;
      ISSUE:   if (add_hs && add_lst)             state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_lst)             state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.DAT_DAT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      strd_q    <= '0;
      addr_q    <= '0;
      iss_cnt   <= '0;
      pop_cnt   <= '0;
      outst_cnt <= '0;
      fifo_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      slot      <= '0;
      pk_dat    <= '0;
      out_dat   <= '0;
      out_vld   <= 1'b0;
      out_lst   <= 1'b0;
      done_zl   <= 1'b0;
    end else begin
      done_zl <= cfg_hs && (bus.CFG_LEN == '0);

      if (cfg_hs) begin
        len_q   <= bus.CFG_LEN;
        strd_q  <= bus.CFG_STRD;
        addr_q  <= bus.CFG_BASE;
        iss_cnt <= '0;
        pop_cnt <= '0;
      end else if (add_hs) begin
        addr_q  <= addr_q + strd_q;
        iss_cnt <= iss_cnt + 1'b1;
      end

      if (add_hs && !pop)      outst_cnt <= outst_cnt + 1'b1;
      else if (!add_hs && pop) outst_cnt <= outst_cnt - 1'b1;

      if (push && !pop)        fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop)   fifo_cnt <= fifo_cnt - 1'b1;

      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

      // a pop in the same cycle as an output handshake may immediately refill the output
      if (out_hs) begin
        out_vld <= 1'b0;
        out_lst <= 1'b0;
      end
      if (pop) begin
        pop_cnt <= pop_cnt + 1'b1;
        if (pk_full || pk_last) begin
          out_vld <= 1'b1;
          out_lst <= pk_last;
          out_dat <= pk_nxt;
          pk_dat  <= '0;
          slot    <= '0;
        end else begin
          pk_dat  <= pk_nxt;
          slot    <= slot + 1'b1;
        end
      end
    end
  end

`ifdef EEG_RDGEN_ERRCHK_EN
  logic [ADD_AW-1:0] ret_cnt;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_cnt <= '0;
      err_q   <= 1'b0;
    end else if (cfg_hs) begin
      ret_cnt <= '0;
      err_q   <= 1'b0;
    end else if (push) begin
      ret_cnt <= ret_cnt + 1'b1;
      if (bus.DAT_LST != (ret_cnt == len_q - 1'b1)) err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  logic unused_dat_lst;
  assign unused_dat_lst = bus.DAT_LST;
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_eeg_wram_rdgen.sv
// Scoreboard bench for eeg_wram_rdgen: a WRAM model returns addr[7:0] as data, expected
// addresses and packed words are queued at job launch and popped as the DUT handshakes them.
module tb_eeg_wram_rdgen;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;
  localparam int unsigned PN = 4;
  localparam int unsigned CN = 4;
`ifdef EEG_RDGEN_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic is_idle, done, err;

  eeg_wram_rdgen_if #(.ADD_AW(AW), .DAT_DW(DW), .PACK_NUM(PN)) bus ();

  eeg_wram_rdgen #(.ADD_AW(AW), .DAT_DW(DW), .PACK_NUM(PN), .CRD_NUM(CN)) dut (
    .clk    (clk),
    .rst    (rst),
    .IS_IDLE(is_idle),
    .DONE   (done),
    .ERR    (err),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic lst; } add_t;
  typedef struct packed { logic [PN*DW-1:0] dat; logic lst; } out_t;
  typedef struct packed { logic [DW-1:0] dat; logic lst; int due; } ret_t;

  add_t add_q[$];
  out_t out_q[$];
  ret_t ret_q[$];

  int n_vec = 0, n_miss = 0;
  int cyc = 0, done_cnt = 0, inflight = 0, max_inflight = 0, last_due = 0;
  int add_idx = 0, bad_lst_idx = -1;
  bit add_rand = 1'b0, out_hold = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // WRAM model + output monitor: drive next-cycle inputs at negedge, then sample.
  initial begin : mon
    add_t          ea;
    out_t          eo;
    ret_t          r;
    bit            add_stall = 1'b0, out_stall = 1'b0;
    logic [AW-1:0] prev_add = '0;
    logic [PN*DW-1:0] prev_out = '0;
    bus.ADD_RDY = 1'b1;
    bus.OUT_RDY = 1'b1;
    bus.DAT_VLD = 1'b0;
    bus.DAT_LST = 1'b0;
    bus.DAT_DAT = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.ADD_RDY = add_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.OUT_RDY = !out_hold;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        bus.DAT_VLD = 1'b1;
        bus.DAT_DAT = r.dat;
        bus.DAT_LST = r.lst;
        inflight--;
      end else begin
        bus.DAT_VLD = 1'b0;
        bus.DAT_LST = 1'b0;
      end
      #1;
      if (!rst) begin
        if (add_stall) begin
          check_val("add_hold_vld", bus.ADD_VLD, 1'b1);
          check_val("add_hold_addr", bus.ADD_ADD, prev_add);
        end
        if (out_stall) begin
          check_val("out_hold_vld", bus.OUT_VLD, 1'b1);
          check_val("out_hold_dat", bus.OUT_DAT, prev_out);
        end
        if (bus.ADD_VLD && bus.ADD_RDY) begin
          if (add_q.size() == 0) check_val("add_unexp", bus.ADD_VLD, 1'b0);
          else begin
            ea = add_q.pop_front();
            check_val("add_addr", bus.ADD_ADD, ea.addr);
            check_val("add_lst", bus.ADD_LST, ea.lst);
          end
        end
        if (bus.OUT_VLD && bus.OUT_RDY) begin
          if (out_q.size() == 0) check_val("out_unexp", bus.OUT_VLD, 1'b0);
          else begin
            eo = out_q.pop_front();
            check_val("out_dat", bus.OUT_DAT, eo.dat);
            check_val("out_lst", bus.OUT_LST, eo.lst);
            if (eo.lst) check_val("done_at_lst", done, 1'b1);
          end
        end
        if (done) done_cnt++;
      end
      // the memory accepts the address regardless of the generator's reset
      if (bus.ADD_VLD && bus.ADD_RDY) begin
        r.dat = bus.ADD_ADD[DW-1:0];
        r.lst = bus.ADD_LST ^ (add_idx == bad_lst_idx);
        r.due = cyc + 2 + int'($urandom_range(0, 2));
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        ret_q.push_back(r);
        add_idx++;
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end
      add_stall = !rst && bus.ADD_VLD && !bus.ADD_RDY;
      out_stall = !rst && bus.OUT_VLD && !bus.OUT_RDY;
      prev_add  = bus.ADD_ADD;
      prev_out  = bus.OUT_DAT;
    end
  end

  task automatic push_exp(input logic [AW-1:0] base, input logic [AW-1:0] strd, input int len);
    logic [AW-1:0]    a;
    logic [PN*DW-1:0] w = '0;
    int               s = 0;
    for (int k = 0; k < len; k++) begin
      a = base + AW'(k) * strd;
      add_q.push_back('{addr: a, lst: (k == len - 1)});
      w[s*DW +: DW] = a[DW-1:0];
      s++;
      if (s == PN || k == len - 1) begin
        out_q.push_back('{dat: w, lst: (k == len - 1)});
        w = '0;
        s = 0;
      end
    end
  endtask

  task automatic issue_cfg(input logic [AW-1:0] base, input logic [AW-1:0] strd, input int len);
    @(negedge clk);
    check_val("cfg_rdy", bus.CFG_RDY, 1'b1);
    add_idx      = 0;
    bus.CFG_VLD  = 1'b1;
    bus.CFG_BASE = base;
    bus.CFG_STRD = strd;
    bus.CFG_LEN  = AW'(len);
    @(negedge clk);
    bus.CFG_VLD  = 1'b0;
  endtask

  task automatic wait_job(input int d0, input int bound, input bit exp_err);
    int i = 0;
    while (i < bound && !(add_q.size() == 0 && out_q.size() == 0 && done_cnt != d0)) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    #2;
    check_val("job_add_left", add_q.size(), 0);
    check_val("job_out_left", out_q.size(), 0);
    check_val("job_done_cnt", done_cnt - d0, 1);
    check_val("job_idle", is_idle, 1'b1);
    check_val("job_err", err, exp_err);
  endtask

  task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] strd, input int len,
                         input bit exp_err);
    int d0 = done_cnt;
    push_exp(base, strd, len);
    issue_cfg(base, strd, len);
    wait_job(d0, 400, exp_err);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0;
    rst          = 1'b1;
    bus.CFG_VLD  = 1'b0;
    bus.CFG_BASE = '0;
    bus.CFG_STRD = '0;
    bus.CFG_LEN  = '0;
    repeat (3) @(negedge clk);
    #2;
    check_val("rst_is_idle", is_idle, 1'b1);
    check_val("rst_cfg_rdy", bus.CFG_RDY, 1'b1);
    check_val("rst_add_vld", bus.ADD_VLD, 1'b0);
    check_val("rst_add_lst", bus.ADD_LST, 1'b0);
    check_val("rst_add_add", bus.ADD_ADD, 0);
    check_val("rst_dat_rdy", bus.DAT_RDY, 1'b1);
    check_val("rst_out_vld", bus.OUT_VLD, 1'b0);
    check_val("rst_out_lst", bus.OUT_LST, 1'b0);
    check_val("rst_out_dat", bus.OUT_DAT, 0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_job(13'h0010, 13'h0001, 8, 1'b0);
    run_job(13'h1FFE, 13'h0001, 4, 1'b0);
    run_job(13'h0001, 13'h0001, 5, 1'b0);

    // output stalled for 20 cycles mid-job
    max_inflight = 0;
    fork
      run_job(13'h0100, 13'h0003, 16, 1'b0);
      begin
        repeat (3) @(negedge clk);
        out_hold = 1'b1;
        repeat (20) @(negedge clk);
        out_hold = 1'b0;
      end
    join
    check_val("max_inflight_ok", max_inflight <= int'(CN), 1'b1);

    add_rand = 1'b1;
    run_job(13'h1F00, 13'h0025, 13, 1'b0);
    add_rand = 1'b0;

    // zero-length job: no address, DONE the cycle after the handshake
    d0 = done_cnt;
    issue_cfg(13'h0040, 13'h0001, 0);
    #2;
    check_val("len0_done", done, 1'b1);
    check_val("len0_idle", is_idle, 1'b1);
    @(negedge clk);
    #2;
    check_val("len0_done_off", done, 1'b0);
    wait_job(d0, 20, 1'b0);

    // reset mid-ISSUE, stale returns must be dropped
    d0 = done_cnt;
    push_exp(13'h0300, 13'h0001, 40);
    issue_cfg(13'h0300, 13'h0001, 40);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    add_q.delete();
    out_q.delete();
    #2;
    check_val("rstmid_idle", is_idle, 1'b1);
    check_val("rstmid_add_vld", bus.ADD_VLD, 1'b0);
    check_val("rstmid_out_vld", bus.OUT_VLD, 1'b0);
    for (int i = 0; i < 50 && ret_q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_val("rstmid_ret_drained", ret_q.size(), 0);
    check_val("rstmid_no_done", done_cnt - d0, 0);
    check_val("rstmid_out_vld2", bus.OUT_VLD, 1'b0);
    run_job(13'h0055, 13'h0002, 9, 1'b0);

    // DAT_LST raised on word 2 of 4
    bad_lst_idx = 1;
    run_job(13'h0200, 13'h0001, 4, ERRCHK);
    bad_lst_idx = -1;
    repeat (5) @(negedge clk);
    #2;
    check_val("err_sticky", err, ERRCHK);
    run_job(13'h0208, 13'h0004, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/eeg_wram_rdgen.md
EEG_WRAM_RDGEN -- requirements
Module: EEG_WRAM_RDGEN

Interface
REQ-001 SHALL have parameter ADD_AW, default 13, WRAM address width.
REQ-002 SHALL have parameter DAT_DW, default 8, WRAM data width.
REQ-003 SHALL have parameter PACK_NUM, default 4, WRAM words packed per output word (power of 2, >=2).
REQ-004 SHALL have parameter CRD_NUM, default 4, max reads outstanding and return-FIFO depth.
REQ-005 SHALL have ports:
 - clk  in  1  single clock
 - rst  in  1  synchronous, active-high reset
 - IS_IDLE  out  1  FSM in IDLE
 - CFG_VLD / CFG_RDY  in/out  1/1  job handshake
 - CFG_BASE / CFG_STRD  in  ADD_AW/ADD_AW  start address / address step
 - CFG_LEN  in  ADD_AW  WRAM words to read
 - ADD_VLD / ADD_LST / ADD_RDY  out/out/in  1/1/1  read-address channel to one WRAM bank
 - ADD_ADD  out  ADD_AW  read address
 - DAT_VLD / DAT_LST / DAT_RDY  in/in/out  1/1/1  read-data channel from WRAM
 - DAT_DAT  in  DAT_DW  read data
 - OUT_VLD / OUT_LST / OUT_RDY  out/out/in  1/1/1  packed-weight channel to engine
 - OUT_DAT  out  PACK_NUM*DAT_DW  packed word
 - DONE  out  1  one-cycle job-complete pulse
 - ERR  out  1  sticky LST-mismatch flag

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE; CFG_RDY=1 only in IDLE.
REQ-007 SHALL, on CFG handshake with CFG_LEN>0, latch BASE/STRD/LEN and enter ISSUE next cycle; first ADD_VLD in that cycle.
REQ-008 SHALL, on CFG handshake with CFG_LEN=0, stay in IDLE, issue no address, pulse DONE next cycle.
REQ-009 SHALL drive address k as (CFG_BASE + k*CFG_STRD) mod 2^ADD_AW, k=0..LEN-1; wrap silently.
REQ-010 SHALL assert ADD_LST with address LEN-1; ISSUE -> DRAIN on that handshake.
REQ-011 SHALL hold ADD_VLD/ADD_ADD/ADD_LST stable until ADD_RDY.
REQ-012 SHALL keep credit = CRD_NUM - (in-flight + FIFO occupancy); ADD_VLD only when credit>0.
REQ-013 SHALL drive DAT_RDY=1 in every state; returned data goes into the CRD_NUM-deep FIFO, which credits make overflow-free; data in IDLE is discarded.
REQ-014 SHALL pack FIFO words LSB-first (first word in OUT_DAT[DAT_DW-1:0]) and assert OUT_VLD the cycle after the PACK_NUM-th word enters the packer.
REQ-015 SHALL zero-fill the upper bytes of the final partial pack when LEN mod PACK_NUM != 0; OUT_LST marks the final pack.
REQ-016 SHALL hold OUT_* stable while OUT_VLD & ~OUT_RDY; the packer stalls, and the FIFO and credits back-pressure address issue.
REQ-017 SHALL, on the OUT_LST handshake, return DRAIN -> IDLE and pulse DONE the same cycle.
REQ-018 SHALL handle a simultaneous FIFO push and pop in one cycle with occupancy unchanged.

Reset
REQ-019 SHALL on rst=1 at a clk edge: FSM=IDLE, counters/FIFO/packer cleared.
REQ-020 SHALL reset outputs as ADD_VLD=0, ADD_LST=0, ADD_ADD=0, OUT_VLD=0, OUT_LST=0, OUT_DAT=0, DONE=0, ERR=0, CFG_RDY=1, IS_IDLE=1, DAT_RDY=1.
REQ-021 SHALL, on reset mid-job, abandon the job; later in-flight returns are dropped per REQ-013.

Configuration
REQ-022 SHALL, with macro EEG_RDGEN_ERRCHK_EN defined, set ERR when DAT_LST disagrees with the expected final-word position; ERR is cleared only by rst or CFG handshake.
REQ-023 SHALL, without EEG_RDGEN_ERRCHK_EN, tie ERR to 0 and ignore DAT_LST.

Verification
REQ-024 SHALL cover: BASE=0x10, STRD=1, LEN=8, RDY always 1 -> addresses 0x10..0x17, LST on 0x17, two OUT words, OUT_LST on second, DONE once.
REQ-025 SHALL cover: BASE=0x1FFE, STRD=1, LEN=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-026 SHALL cover: LEN=5, data 0x01..0x05 -> OUT_DAT 0x04030201, then 0x00000005 with OUT_LST.
REQ-027 SHALL cover: OUT_RDY=0 for 20 cycles -> at most 4 outstanding addresses, no data lost, ordering kept.
REQ-028 SHALL cover: LEN=0 -> no ADD_VLD, DONE pulse next cycle; rst asserted mid-ISSUE -> IDLE next cycle, stale returns dropped, next job correct.
REQ-029 SHALL cover: with EEG_RDGEN_ERRCHK_EN, DAT_LST on word 2 of 4 -> ERR=1 until next CFG handshake.
